// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory path: size encodings, responder FSM
// states and the lane helpers used by the store and load datapaths.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    // Byte write enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 4'b0001 << addr_lo;
            SZ_HALF: return 4'b0011 << {addr_lo[1], 1'b0};
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Size 2'b11 has no legal encoding, so it is reported like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    // Replicate right-justified store data so every enabled lane sees its bytes.
    function automatic logic [31:0] place_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane extraction with sign/zero extension. Shared with the
// cache refill path, so it carries no state of its own.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] ram_word_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane and extend it to 32 bits; word loads pass through.
    always_comb begin
        byte_sel = ram_word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? ram_word_i[31:16] : ram_word_i[15:0];
        case (size_i)
            SZ_BYTE: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
            default: data_o = ram_word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: accepts one load/store at a time, drives a synchronous
// single-port RAM with RAM_LATENCY read latency and returns a one-cycle response.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              ram_ena,
    output logic [3:0]        ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [31:0]       ram_dina,
    input  logic [31:0]       ram_douta
);

    localparam logic [2:0] WaitInit = 3'(RAM_LATENCY - 1);

    state_e            state_q;
    logic              write_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        addr_lo_q;
    logic [2:0]        cnt_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [31:0]       resp_rdata_q;
    logic              ram_ena_q;
    logic [3:0]        ram_wea_q;
    logic [ADDR_W-1:0] ram_addra_q;
    logic [31:0]       ram_dina_q;
    logic [31:0]       load_data;

    load_align u_load_align (
        .ram_word_i (ram_douta),
        .size_i     (size_q),
        .addr_lo_i  (addr_lo_q),
        .signed_i   (signed_q),
        .data_o     (load_data)
    );

    // Request FSM; outputs are registered on the transition into the state that shows them.
    always_ff @(posedge clka) begin
        if (rst) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            addr_lo_q    <= 2'b00;
            cnt_q        <= 3'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            ram_ena_q    <= 1'b0;
            ram_wea_q    <= 4'b0000;
            ram_addra_q  <= '0;
            ram_dina_q   <= 32'h0;
        end else begin
            // Strobes are single-cycle unless a branch below re-asserts them.
            ram_ena_q    <= 1'b0;
            ram_wea_q    <= 4'b0000;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        addr_lo_q <= req_addr[1:0];
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            // Skip the RAM entirely and answer next cycle.
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            state_q     <= StIssue;
                            ram_ena_q   <= 1'b1;
                            ram_addra_q <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (req_write) begin
                                ram_wea_q  <= lane_mask(req_size, req_addr[1:0]);
                                ram_dina_q <= place_wdata(req_size, req_wdata);
                            end
                        end
                    end
                end
                StIssue: begin
                    if (write_q) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                    end else begin
                        state_q <= StWait;
                        cnt_q   <= WaitInit;
                    end
                end
                StWait: begin
                    if (cnt_q == 3'd0) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_data;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Reset must suppress RAM strobes and responses in the very cycle it is asserted.
    always_comb begin
        req_ready  = (state_q == StIdle) && !rst;
        resp_valid = resp_valid_q & ~rst;
        resp_err   = resp_err_q & ~rst;
        resp_rdata = resp_rdata_q;
        ram_ena    = ram_ena_q & ~rst;
        ram_wea    = ram_wea_q & {4{~rst}};
        ram_addra  = ram_addra_q;
        ram_dina   = ram_dina_q;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with RAM_LATENCY=1 and one with RAM_LATENCY=3,
// each attached to a small byte-writable RAM model with the matching read latency.
module tb_data_mem_responder;

    logic        clka = 1'b0;
    logic        rst;

    logic        a_req_valid, a_req_ready, a_req_write, a_req_signed;
    logic [1:0]  a_req_size;
    logic [31:0] a_req_addr, a_req_wdata;
    logic        a_resp_valid, a_resp_err, a_ram_ena;
    logic [31:0] a_resp_rdata, a_ram_addra, a_ram_dina, a_ram_douta;
    logic [3:0]  a_ram_wea;

    logic        b_req_valid, b_req_ready, b_req_write, b_req_signed;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_resp_valid, b_resp_err, b_ram_ena;
    logic [31:0] b_resp_rdata, b_ram_addra, b_ram_dina, b_ram_douta;
    logic [3:0]  b_ram_wea;

    int tests = 0;
    int fails = 0;

    always #5 clka = ~clka;

    data_mem_responder #(.RAM_LATENCY(1), .ADDR_W(32)) dut_a (
        .clka(clka), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_size(a_req_size), .req_signed(a_req_signed), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .resp_valid(a_resp_valid), .resp_err(a_resp_err),
        .resp_rdata(a_resp_rdata), .ram_ena(a_ram_ena), .ram_wea(a_ram_wea),
        .ram_addra(a_ram_addra), .ram_dina(a_ram_dina), .ram_douta(a_ram_douta)
    );

    data_mem_responder #(.RAM_LATENCY(3), .ADDR_W(32)) dut_b (
        .clka(clka), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_err(b_resp_err),
        .resp_rdata(b_resp_rdata), .ram_ena(b_ram_ena), .ram_wea(b_ram_wea),
        .ram_addra(b_ram_addra), .ram_dina(b_ram_dina), .ram_douta(b_ram_douta)
    );

    // RAM models: byte-enable writes, read data delayed by 1 and 3 cycles.
    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    logic [31:0] a_rd, b_p0, b_p1, b_p2;

    always @(posedge clka) begin
        if (a_ram_ena) begin
            a_rd <= mem_a[a_ram_addra[7:2]];
            for (int i = 0; i < 4; i++)
                if (a_ram_wea[i]) mem_a[a_ram_addra[7:2]][8*i +: 8] <= a_ram_dina[8*i +: 8];
        end
    end

    always @(posedge clka) begin
        if (b_ram_ena) begin
            b_p0 <= mem_b[b_ram_addra[7:2]];
            for (int i = 0; i < 4; i++)
                if (b_ram_wea[i]) mem_b[b_ram_addra[7:2]][8*i +: 8] <= b_ram_dina[8*i +: 8];
        end
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end

    assign a_ram_douta = a_rd;
    assign b_ram_douta = b_p2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request on instance 0 (latency 1) or 1 (latency 3), hold it until
    // accepted, then count negedges until resp_valid. Returns to the caller at the
    // negedge where the response is visible.
    task automatic do_req(input int which, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int wait_cyc, output int lat, output int ena_seen,
                          output int ready_low, output logic [3:0] iss_wea,
                          output logic [31:0] iss_addr, output logic [31:0] iss_dina);
        if (which == 0) begin
            a_req_write = w; a_req_size = sz; a_req_signed = sg;
            a_req_addr = addr; a_req_wdata = wd; a_req_valid = 1'b1;
        end else begin
            b_req_write = w; b_req_size = sz; b_req_signed = sg;
            b_req_addr = addr; b_req_wdata = wd; b_req_valid = 1'b1;
        end
        wait_cyc = 0;
        while (!((which == 0) ? a_req_ready : b_req_ready) && wait_cyc < 10) begin
            @(negedge clka);
            wait_cyc++;
        end
        lat = 0; ena_seen = 0; ready_low = 0;
        iss_wea = 4'hx; iss_addr = 32'hx; iss_dina = 32'hx;
        do begin
            @(negedge clka);
            lat++;
            a_req_valid = 1'b0;
            b_req_valid = 1'b0;
            if ((which == 0) ? a_ram_ena : b_ram_ena) ena_seen++;
            if (!((which == 0) ? a_req_ready : b_req_ready)) ready_low++;
            if (lat == 1) begin
                iss_wea  = (which == 0) ? a_ram_wea : b_ram_wea;
                iss_addr = (which == 0) ? a_ram_addra : b_ram_addra;
                iss_dina = (which == 0) ? a_ram_dina : b_ram_dina;
            end
        end while (!((which == 0) ? a_resp_valid : b_resp_valid) && lat < 20);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc, lat, ena, rlow, seen;
        logic [3:0]  wea;
        logic [31:0] iaddr, idina;

        rst = 1'b1;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_size = 2'b00; a_req_signed = 1'b0;
        a_req_addr = 32'h0; a_req_wdata = 32'h0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_size = 2'b00; b_req_signed = 1'b0;
        b_req_addr = 32'h0; b_req_wdata = 32'h0;

        // Reset state.
        @(negedge clka);
        check("rst_ready", {31'h0, a_req_ready}, 32'h0);
        check("rst_resp_valid", {31'h0, a_resp_valid}, 32'h0);
        check("rst_ram_ena", {31'h0, a_ram_ena}, 32'h0);
        check("rst_ram_wea", {28'h0, a_ram_wea}, 32'h0);
        @(negedge clka);
        rst = 1'b0;
        #1;
        check("post_rst_ready_a", {31'h0, a_req_ready}, 32'h1);
        check("post_rst_ready_b", {31'h0, b_req_ready}, 32'h1);
        check("post_rst_rdata", a_resp_rdata, 32'h0);
        check("post_rst_addra", a_ram_addra, 32'h0);
        check("post_rst_dina", a_ram_dina, 32'h0);

        // Preload 0x80FF7F01 at 0x10 in both RAMs through word stores.
        do_req(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, wc, lat, ena, rlow, wea, iaddr, idina);
        check("wst_lat", 32'(lat), 32'd2);
        check("wst_wea", {28'h0, wea}, 32'hF);
        check("wst_addr", iaddr, 32'h10);
        check("wst_dina", idina, 32'h80FF7F01);
        check("wst_err", {31'h0, a_resp_err}, 32'h0);
        do_req(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, wc, lat, ena, rlow, wea, iaddr, idina);
        check("b_wst_lat", 32'(lat), 32'd2);

        // Byte loads with extension.
        do_req(0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, wc, lat, ena, rlow, wea, iaddr, idina);
        check("lb11_lat", 32'(lat), 32'd3);
        check("lb11_wea", {28'h0, wea}, 32'h0);
        check("lb11_data", a_resp_rdata, 32'h0000007F);
        check("lb11_err", {31'h0, a_resp_err}, 32'h0);
        do_req(0, 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, wc, lat, ena, rlow, wea, iaddr, idina);
        check("lb12_data", a_resp_rdata, 32'hFFFFFFFF);
        do_req(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, wc, lat, ena, rlow, wea, iaddr, idina);
        check("lbu13_data", a_resp_rdata, 32'h00000080);

        // Misaligned word load: immediate error, no RAM access, rdata held.
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, wc, lat, ena, rlow, wea, iaddr, idina);
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_err", {31'h0, a_resp_err}, 32'h1);
        check("mis_ena", 32'(ena), 32'd0);
        check("mis_rdata", a_resp_rdata, 32'h00000080);

        // Illegal size is reported as an error too.
        do_req(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, wc, lat, ena, rlow, wea, iaddr, idina);
        check("ill_err", {31'h0, a_resp_err}, 32'h1);
        check("ill_ena", 32'(ena), 32'd0);

        // Byte store at 0x13.
        do_req(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5, wc, lat, ena, rlow, wea, iaddr, idina);
        check("sb_wea", {28'h0, wea}, 32'h8);
        check("sb_addr", iaddr, 32'h10);
        check("sb_dina", idina, 32'hA5A5A5A5);
        check("sb_lat", 32'(lat), 32'd2);
        check("sb_err", {31'h0, a_resp_err}, 32'h0);
        check("sb_rdata_held", a_resp_rdata, 32'h00000080);
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, wc, lat, ena, rlow, wea, iaddr, idina);
        check("sb_readback", a_resp_rdata, 32'hA5FF7F01);

        // Half load on the latency-3 instance.
        do_req(1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, wc, lat, ena, rlow, wea, iaddr, idina);
        check("lh3_lat", 32'(lat), 32'd5);
        check("lh3_data", b_resp_rdata, 32'hFFFF80FF);
        check("lh3_ready_low", 32'(rlow), 32'd5);
        @(negedge clka);
        check("lh3_ready_after", {31'h0, b_req_ready}, 32'h1);

        // Back-to-back store then load at 0x20.
        do_req(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, wc, lat, ena, rlow, wea, iaddr, idina);
        check("b2b_st_lat", 32'(lat), 32'd2);
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, wc, lat, ena, rlow, wea, iaddr, idina);
        check("b2b_accept_wait", 32'(wc), 32'd1);
        check("b2b_ld_data", a_resp_rdata, 32'hDEADBEEF);

        // Reset during the ISSUE cycle of a store must not write.
        do_req(0, 1'b1, 2'b10, 1'b0, 32'h24, 32'h11223344, wc, lat, ena, rlow, wea, iaddr, idina);
        @(negedge clka);
        a_req_write = 1'b1; a_req_size = 2'b10; a_req_addr = 32'h24;
        a_req_wdata = 32'hFFFFFFFF; a_req_valid = 1'b1;
        @(negedge clka);
        a_req_valid = 1'b0;
        check("abort_issue_seen", {31'h0, a_ram_ena}, 32'h1);
        rst = 1'b1;
        #1;
        check("abort_wea", {28'h0, a_ram_wea}, 32'h0);
        check("abort_ena", {31'h0, a_ram_ena}, 32'h0);
        @(negedge clka);
        rst = 1'b0;
        #1;
        check("abort_ready", {31'h0, a_req_ready}, 32'h1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clka);
            if (a_resp_valid) seen++;
        end
        check("abort_no_resp", 32'(seen), 32'd0);
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, wc, lat, ena, rlow, wea, iaddr, idina);
        check("abort_mem_kept", a_resp_rdata, 32'h11223344);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
